sensor_request_unit: RTL and testbench
======================================

SENSOR_REQUEST_UNIT -- requirements
Module: sensor_request_unit

Interface
REQ-001 Parameter: DEBOUNCE, 8'd16, number of consecutive synchronized samples needed to qualify a sensor edge; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: sensor_raw  input  1  raw vehicle loop detector, asynchronous to clk, may bounce.
REQ-005 Port: req_ack  input  1  controller acknowledge of veh_req.
REQ-006 Port: count_clear  input  1  synchronous clear of veh_count.
REQ-007 Port: veh_present  output  1  debounced vehicle-present level.
REQ-008 Port: veh_req  output  1  latched service request to the light controller.
REQ-009 Port: veh_count  output  8  qualified vehicle arrivals, saturating.
REQ-010 Port: veh_state  output  2  current FSM state encoding.

Function
REQ-011 sensor_raw SHALL pass through a 2-flop synchronizer; sensor_s is the second flop output; no other logic SHALL sample sensor_raw.
REQ-012 FSM states SHALL be IDLE=2'd0, QUALIFY=2'd1, PRESENT=2'd2, RELEASE=2'd3; veh_state reflects the registered state.
REQ-013 An 8-bit debounce counter deb_cnt SHALL exist; it is 0 in IDLE and PRESENT.
REQ-014 IDLE: sensor_s=1 -> QUALIFY, deb_cnt=1; else stay.
REQ-015 QUALIFY: sensor_s=0 -> IDLE, deb_cnt=0; sensor_s=1 and deb_cnt==DEBOUNCE-1 -> PRESENT, deb_cnt=0; otherwise deb_cnt+1.
REQ-016 PRESENT: sensor_s=0 -> RELEASE, deb_cnt=1; else stay.
REQ-017 RELEASE: sensor_s=1 -> PRESENT, deb_cnt=0; sensor_s=0 and deb_cnt==DEBOUNCE-1 -> IDLE, deb_cnt=0; otherwise deb_cnt+1.
REQ-018 veh_present SHALL be registered, 1 exactly while state is PRESENT or RELEASE.
REQ-019 With sensor_raw held high from before edge E0, veh_present SHALL go high after edge E0+DEBOUNCE+1 (latency DEBOUNCE+2 edges including E0); release latency SHALL be symmetric.
REQ-020 A glitch shorter than DEBOUNCE synchronized samples SHALL return to the prior stable state with no output change.
REQ-021 veh_req SHALL set on the QUALIFY->PRESENT transition and clear on the edge after req_ack=1 is sampled while veh_req=1.
REQ-022 Set and ack in the same cycle: veh_req SHALL remain 1 (new arrival wins).
REQ-023 req_ack while veh_req=0 SHALL be ignored; veh_req SHALL stay 1 indefinitely until acked, independent of veh_present.
REQ-024 veh_count SHALL increment by 1 on each QUALIFY->PRESENT transition, saturating at 8'd255 (no wrap).
REQ-025 count_clear=1 SHALL set veh_count to 0; clear with simultaneous increment SHALL yield 8'd1.
REQ-026 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 reset=0 SHALL immediately force synchronizer flops 0, state IDLE, deb_cnt 0, veh_present 0, veh_req 0, veh_count 0, veh_state 2'd0, regardless of clk.
REQ-028 Reset asserted mid-qualification or with veh_req pending SHALL discard all progress; no request survives reset.
REQ-029 After reset rises, the first rising edge SHALL be a normal functional edge; sensor_raw already high then requalifies from IDLE.

Verification
REQ-030 DEBOUNCE=4, sensor_raw high held -> veh_present=1, veh_req=1, veh_count=1 after the 6th edge; veh_state sequence 0,1,1,1,2.
REQ-031 DEBOUNCE=4, sensor_raw high 3 synchronized cycles then low -> veh_present, veh_req stay 0, veh_count 0, state returns 0.
REQ-032 veh_req=1, req_ack pulsed 1 cycle -> veh_req 0 next edge; req_ack with veh_req=0 -> no change.
REQ-033 Second arrival qualifying in the cycle req_ack=1 is sampled -> veh_req stays 1, veh_count increments.
REQ-034 Preload veh_count 8'd255 via 255 arrivals, one more arrival -> stays 255; count_clear with arrival same cycle -> 8'd1.
REQ-035 reset driven low between clock edges while in QUALIFY with veh_req=1 -> all outputs 0 before next edge.

Source files
------------

// File: rtl/sensor_request_unit.sv
// sensor_request_unit: debounces a loop detector and raises a latched service request with a saturating arrival count.
module sensor_request_unit #(
    parameter logic [7:0] DEBOUNCE = 8'd16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_raw,
    input  logic       req_ack,
    input  logic       count_clear,
    output logic       veh_present,
    output logic       veh_req,
    output logic [7:0] veh_count,
    output logic [1:0] veh_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, QUALIFY = 2'd1, PRESENT = 2'd2, RELEASE = 2'd3} state_t;
    localparam logic [7:0] LAST = DEBOUNCE - 8'd1;
    state_t     state_q, state_d;
    logic [7:0] deb_q, deb_d, count_q, count_d;
    logic       sync_q, sensor_s, present_q, present_d, req_q, req_d, arrive;
    always_comb begin
        state_d = state_q;
        deb_d   = 8'd0;
        case (state_q)
            IDLE:    if (sensor_s) begin
                         state_d = QUALIFY;
                         deb_d   = 8'd1;
                     end
            QUALIFY: if (!sensor_s) state_d = IDLE;
                     else if (deb_q == LAST) state_d = PRESENT;
                     else deb_d = deb_q + 8'd1;
            PRESENT: if (!sensor_s) begin
                         state_d = RELEASE;
                         deb_d   = 8'd1;
                     end
            default: if (sensor_s) state_d = PRESENT;
                     else if (deb_q == LAST) state_d = IDLE;
                     else deb_d = deb_q + 8'd1;
        endcase
    end
    // outputs follow the next state so they change on the same edge as veh_state
    assign arrive    = (state_q == QUALIFY) && (state_d == PRESENT);
    assign present_d = (state_d == PRESENT) || (state_d == RELEASE);
    assign req_d     = arrive || (req_q && !req_ack);
    assign count_d   = count_clear ? {7'd0, arrive} :
                       (arrive && count_q != 8'hFF) ? count_q + 8'd1 : count_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= 1'b0;
            sensor_s  <= 1'b0;
            state_q   <= IDLE;
            deb_q     <= 8'd0;
            present_q <= 1'b0;
            req_q     <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            sync_q    <= sensor_raw;
            sensor_s  <= sync_q;
            state_q   <= state_d;
            deb_q     <= deb_d;
            present_q <= present_d;
            req_q     <= req_d;
            count_q   <= count_d;
        end
    end
    assign veh_present = present_q;
    assign veh_req     = req_q;
    assign veh_count   = count_q;
    assign veh_state   = state_q;
endmodule

// File: tb/tb_sensor_request_unit.sv
// tb_sensor_request_unit: directed vectors with hand-computed expectations, DEBOUNCE=4.
module tb_sensor_request_unit;
    logic       clk = 1'b0, reset = 1'b0, sensor_raw = 1'b0, req_ack = 1'b0, count_clear = 1'b0;
    logic       veh_present, veh_req;
    logic [7:0] veh_count;
    logic [1:0] veh_state;
    int         vectors = 0, miscompares = 0;
    sensor_request_unit #(.DEBOUNCE(8'd4)) dut (
        .clk(clk), .reset(reset), .sensor_raw(sensor_raw), .req_ack(req_ack),
        .count_clear(count_clear), .veh_present(veh_present), .veh_req(veh_req),
        .veh_count(veh_count), .veh_state(veh_state)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic arrival();
        sensor_raw = 1'b1;
        repeat (6) tick();
        sensor_raw = 1'b0;
        repeat (6) tick();
    endtask
    initial begin
        #3;
        chk("rst_present", veh_present, 0);
        chk("rst_req", veh_req, 0);
        chk("rst_count", veh_count, 0);
        chk("rst_state", veh_state, 0);
        repeat (2) tick();
        @(negedge clk) reset = 1'b1;
        tick();
        // arrival: state after E0..E5 is 0,0,1,1,1,2
        sensor_raw = 1'b1;
        tick(); chk("arr_e0", veh_state, 0);
        tick(); chk("arr_e1", veh_state, 0);
        tick(); chk("arr_e2", veh_state, 1);
        tick(); chk("arr_e3", veh_state, 1);
        tick(); chk("arr_e4", veh_state, 1);
        chk("arr_e4_present", veh_present, 0);
        tick(); chk("arr_e5", veh_state, 2);
        chk("arr_present", veh_present, 1);
        chk("arr_req", veh_req, 1);
        chk("arr_count", veh_count, 1);
        repeat (3) tick();
        chk("hold_state", veh_state, 2);
        sensor_raw = 1'b0;
        repeat (3) tick();
        chk("rel_e2", veh_state, 3);
        tick(); tick();
        chk("rel_e4_present", veh_present, 1);
        tick();
        chk("rel_e5_present", veh_present, 0);
        chk("rel_e5_state", veh_state, 0);
        chk("req_survives_release", veh_req, 1);
        // acknowledge, then a stray ack
        req_ack = 1'b1; tick(); req_ack = 1'b0;
        chk("ack_clears", veh_req, 0);
        req_ack = 1'b1; tick(); req_ack = 1'b0;
        chk("stray_ack", veh_req, 0);
        chk("stray_ack_count", veh_count, 1);
        // glitch of DEBOUNCE-1 synchronized samples
        sensor_raw = 1'b1;
        repeat (3) tick();
        sensor_raw = 1'b0;
        tick(); tick();
        chk("glitch_e4_state", veh_state, 1);
        tick();
        chk("glitch_e5_state", veh_state, 0);
        chk("glitch_present", veh_present, 0);
        chk("glitch_req", veh_req, 0);
        chk("glitch_count", veh_count, 1);
        repeat (4) tick();
        // arrival coinciding with ack: new arrival wins
        arrival();
        chk("arr2_count", veh_count, 2);
        sensor_raw = 1'b1;
        repeat (5) tick();
        req_ack = 1'b1; tick(); req_ack = 1'b0;
        chk("set_ack_req", veh_req, 1);
        chk("set_ack_count", veh_count, 3);
        sensor_raw = 1'b0;
        repeat (6) tick();
        req_ack = 1'b1; tick(); req_ack = 1'b0;
        chk("ack_after_tie", veh_req, 0);
        // saturation
        repeat (252) arrival();
        chk("count_255", veh_count, 255);
        arrival();
        chk("count_sat", veh_count, 255);
        sensor_raw = 1'b1;
        repeat (5) tick();
        count_clear = 1'b1; tick(); count_clear = 1'b0;
        chk("clear_with_arrival", veh_count, 1);
        sensor_raw = 1'b0;
        repeat (6) tick();
        count_clear = 1'b1; tick(); count_clear = 1'b0;
        chk("clear_only", veh_count, 0);
        // async reset mid-qualification with request pending
        sensor_raw = 1'b1;
        repeat (3) tick();
        chk("pre_rst_state", veh_state, 1);
        chk("pre_rst_req", veh_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", veh_state, 0);
        chk("async_rst_req", veh_req, 0);
        chk("async_rst_count", veh_count, 0);
        chk("async_rst_present", veh_present, 0);
        tick();
        @(negedge clk) reset = 1'b1;
        repeat (5) tick();
        chk("requal_e4_state", veh_state, 1);
        tick();
        chk("requal_present", veh_present, 1);
        chk("requal_count", veh_count, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
